reg_write_decoder_sb: RTL and testbench

//   Parametrised successor of the 3-to-8 decoder: decodes the writeback register

---
 rtl/reg_write_decoder_sb.sv | 80 ++++++++
 tb/tb_reg_write_decoder_sb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_decoder_sb.sv
// Writeback address decoder with a per-register busy scoreboard: registered one-hot
// write enables, combinational issue_ready / RAW hazard flags, sticky stray-writeback error.
module reg_write_decoder_sb #(
  parameter int ADDR_W      = 3,
  parameter int NREG        = 1 << ADDR_W,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              hazard1,
  output logic              hazard2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [NREG-1:0]   we_onehot,
  output logic [NREG-1:0]   busy,
  output logic              err_stray
);

  // Clears bit 0 when register 0 is hardwired, so it can never be written or marked busy.
  localparam logic [NREG-1:0] ZMASK = {{(NREG-1){1'b1}}, ~ZERO_REG_RO};

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] r_we;
  logic            r_err;

  logic [NREG-1:0] w_wb_dec;
  logic [NREG-1:0] w_iss_dec;
  logic [NREG-1:0] w_wb_clr;
  logic [NREG-1:0] w_iss_set;
  logic            w_wb_hit_iss;
  logic            w_wb_hit_rs1;
  logic            w_wb_hit_rs2;
  logic            w_stray;

  always_comb begin
    w_wb_dec            = '0;
    w_wb_dec[wb_addr]   = 1'b1;
    w_iss_dec           = '0;
    w_iss_dec[issue_addr] = 1'b1;
  end

  assign w_wb_clr     = wb_valid ? (w_wb_dec & ZMASK) : '0;
  assign w_wb_hit_iss = wb_valid && (wb_addr == issue_addr);
  assign w_wb_hit_rs1 = wb_valid && (wb_addr == rs1_addr);
  assign w_wb_hit_rs2 = wb_valid && (wb_addr == rs2_addr);

  // A writeback landing this cycle frees the register, so a WAW issue may proceed.
  assign issue_ready  = !r_busy[issue_addr] || w_wb_hit_iss;
  assign w_iss_set    = (issue_valid && issue_ready) ? (w_iss_dec & ZMASK) : '0;

  // Hazards look at busy before this cycle's issue; same-cycle writeback bypasses.
  assign hazard1      = r_busy[rs1_addr] && !w_wb_hit_rs1;
  assign hazard2      = r_busy[rs2_addr] && !w_wb_hit_rs2;

  assign w_stray      = wb_valid && !r_busy[wb_addr] &&
                        !(ZERO_REG_RO && (wb_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_we   <= '0;
      r_err  <= 1'b0;
    end else begin
      // Set after clear: a new issue to a register retiring this cycle takes ownership.
      r_busy <= (r_busy & ~w_wb_clr) | w_iss_set;
      r_we   <= w_wb_clr;
      r_err  <= r_err | w_stray;
    end
  end

  assign busy      = r_busy;
  assign we_onehot = r_we;
  assign err_stray = r_err;

endmodule

// File: tb/tb_reg_write_decoder_sb.sv
// Scoreboard bench: default build (ADDR_W=3, reg0 hardwired) against a reference model,
// plus directed checks on a ZERO_REG_RO=0 build and an ADDR_W=5 build.
module tb_reg_write_decoder_sb;

  logic clk;
  logic rst;

  logic       issue_valid, wb_valid;
  logic [2:0] issue_addr, rs1_addr, rs2_addr, wb_addr;
  logic       issue_ready, hazard1, hazard2, err_stray;
  logic [7:0] we_onehot, busy;

  logic       z0_issue_valid, z0_wb_valid;
  logic [2:0] z0_issue_addr, z0_rs1_addr, z0_rs2_addr, z0_wb_addr;
  logic       z0_issue_ready, z0_hazard1, z0_hazard2, z0_err_stray;
  logic [7:0] z0_we_onehot, z0_busy;

  logic        w5_issue_valid, w5_wb_valid;
  logic [4:0]  w5_issue_addr, w5_rs1_addr, w5_rs2_addr, w5_wb_addr;
  logic        w5_issue_ready, w5_hazard1, w5_hazard2, w5_err_stray;
  logic [31:0] w5_we_onehot, w5_busy;

  reg_write_decoder_sb #(.ADDR_W(3), .ZERO_REG_RO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard1(hazard1), .hazard2(hazard2),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .we_onehot(we_onehot), .busy(busy), .err_stray(err_stray));

  reg_write_decoder_sb #(.ADDR_W(3), .ZERO_REG_RO(1'b0)) dut_z0 (
    .clk(clk), .rst(rst),
    .issue_valid(z0_issue_valid), .issue_addr(z0_issue_addr), .issue_ready(z0_issue_ready),
    .rs1_addr(z0_rs1_addr), .rs2_addr(z0_rs2_addr), .hazard1(z0_hazard1), .hazard2(z0_hazard2),
    .wb_valid(z0_wb_valid), .wb_addr(z0_wb_addr),
    .we_onehot(z0_we_onehot), .busy(z0_busy), .err_stray(z0_err_stray));

  reg_write_decoder_sb #(.ADDR_W(5), .ZERO_REG_RO(1'b1)) dut_w5 (
    .clk(clk), .rst(rst),
    .issue_valid(w5_issue_valid), .issue_addr(w5_issue_addr), .issue_ready(w5_issue_ready),
    .rs1_addr(w5_rs1_addr), .rs2_addr(w5_rs2_addr), .hazard1(w5_hazard1), .hazard2(w5_hazard2),
    .wb_valid(w5_wb_valid), .wb_addr(w5_wb_addr),
    .we_onehot(w5_we_onehot), .busy(w5_busy), .err_stray(w5_err_stray));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_busy;
  logic        m_err;
  logic [16:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One cycle on the default build: drive, check comb outputs against the model,
  // push next-state expectation, then pop and compare after the edge.
  task automatic step(input logic iv, input logic [2:0] ia, input logic [2:0] r1,
                      input logic [2:0] r2, input logic wv, input logic [2:0] wa,
                      input logic rs);
    logic [7:0]  set, clr, nb, we;
    logic        rdy, h1, h2, ne;
    logic [16:0] exp;
    issue_valid = iv; issue_addr = ia; rs1_addr = r1; rs2_addr = r2;
    wb_valid = wv; wb_addr = wa; rst = rs;
    #1;
    rdy = (ia == 3'd0) || !m_busy[ia] || (wv && wa == ia);
    h1  = (r1 != 3'd0) && m_busy[r1] && !(wv && wa == r1);
    h2  = (r2 != 3'd0) && m_busy[r2] && !(wv && wa == r2);
    check("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
    check("hazard1", {31'd0, hazard1}, {31'd0, h1});
    check("hazard2", {31'd0, hazard2}, {31'd0, h2});
    clr = (wv && wa != 3'd0) ? (8'h01 << wa) : 8'h00;
    set = (iv && rdy && ia != 3'd0) ? (8'h01 << ia) : 8'h00;
    if (rs) begin
      nb = 8'h00; we = 8'h00; ne = 1'b0;
    end else begin
      nb = (m_busy & ~clr) | set;
      we = clr;
      ne = m_err | (wv && !m_busy[wa] && wa != 3'd0);
    end
    sb_q.push_back({we, nb, ne});
    m_busy = nb; m_err = ne;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check("we_onehot", {24'd0, we_onehot}, {24'd0, exp[16:9]});
      check("busy", {24'd0, busy}, {24'd0, exp[8:1]});
      check("err_stray", {31'd0, err_stray}, {31'd0, exp[0]});
    end
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_addr = 0; rs1_addr = 0; rs2_addr = 0; wb_valid = 0; wb_addr = 0;
    z0_issue_valid = 0; z0_issue_addr = 0; z0_rs1_addr = 0; z0_rs2_addr = 0;
    z0_wb_valid = 0; z0_wb_addr = 0;
    w5_issue_valid = 0; w5_issue_addr = 0; w5_rs1_addr = 0; w5_rs2_addr = 0;
    w5_wb_valid = 0; w5_wb_addr = 0;
    m_busy = 8'h00; m_err = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset state
    step(0, 0, 0, 0, 0, 0, 1);

    // decode sweep, stray error from addr 1 onward
    for (int a = 0; a < 8; a++) step(0, 0, 0, 0, 1, a[2:0], 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // issue 5, WAW stall + RAW hazard, then writeback
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 5, 5, 0, 0, 0, 0);
    step(0, 0, 5, 5, 1, 5, 0);

    // same-cycle writeback and reissue to r3
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 3, 0, 3, 1, 3, 0);
    step(0, 0, 3, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0);

    // hardwired r0
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0);

    // busy=0x66 then reset with a colliding writeback
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0);
    step(1, 6, 1, 2, 0, 0, 0);
    check("busy_66", {24'd0, busy}, 32'h66);
    step(0, 0, 0, 0, 1, 2, 1);

    // random traffic
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 39) == 0));
    issue_valid = 0; wb_valid = 0; rst = 0;

    // ZERO_REG_RO=0: r0 behaves like any other register
    z0_issue_valid = 1; z0_issue_addr = 0; z0_rs1_addr = 0;
    #1;
    check("z0_ready0", {31'd0, z0_issue_ready}, 32'd1);
    check("z0_haz0", {31'd0, z0_hazard1}, 32'd0);
    @(posedge clk); #1;
    check("z0_busy", {24'd0, z0_busy}, 32'h01);
    check("z0_haz1", {31'd0, z0_hazard1}, 32'd1);
    check("z0_ready1", {31'd0, z0_issue_ready}, 32'd0);
    z0_issue_valid = 0; z0_wb_valid = 1; z0_wb_addr = 0;
    @(posedge clk); #1;
    z0_wb_valid = 0;
    check("z0_we", {24'd0, z0_we_onehot}, 32'h01);
    check("z0_busy_clr", {24'd0, z0_busy}, 32'h00);
    check("z0_err", {31'd0, z0_err_stray}, 32'd0);

    // ADDR_W=5: top register
    w5_issue_valid = 1; w5_issue_addr = 5'd31;
    @(posedge clk); #1;
    w5_issue_valid = 0;
    check("w5_busy_set", w5_busy, 32'h8000_0000);
    w5_wb_valid = 1; w5_wb_addr = 5'd31;
    @(posedge clk); #1;
    w5_wb_valid = 0;
    check("w5_busy_clr", w5_busy, 32'h0);
    check("w5_we", w5_we_onehot, 32'h8000_0000);
    check("w5_err", {31'd0, w5_err_stray}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
